// File: rtl/facq_prn_packer.sv
// Purpose : packs the serial chip stream of the fast-acquisition PRN generator
//           into WORD_W-bit words and writes them to the acquisition code memory.
//           It also drives the generator (init pulse, shift enable).
// Latency : start -> gen_init 1 cycle; chip k in the gen_we cycle; its word is
//           written the cycle after the word completes; done 1 cycle after the
//           last accepted write.
// Backpr. : a pending write (mem_we & ~mem_ready) holds address/data and
//           freezes gen_we, so no chip is lost and no word is overwritten.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start, abort          begin a fill (ignored unless idle) / cancel a fill
//   chip_num, base_addr   chips to capture and first word address (sampled with start)
//   gen_init, gen_we      generator do_init pulse and shift enable
//   chip_in               generator serial output, sampled when gen_we is high
//   mem_we/mem_addr/mem_wdata, mem_ready   write channel, valid/ready handshake
//   busy, done            fill in progress / one-cycle completion pulse
//
// Build option: define FACQ_PRN_PACK_MSB_FIRST_EN to place the first chip of
// each word at bit WORD_W-1 (zero padding then lands in the low bits).
// Default is LSB-first with zero padding in the high bits.

module facq_prn_packer #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  chip_num,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              gen_init,
  output logic              gen_we,
  input  logic              chip_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int FILL_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [CNT_W-1:0]  chips_left_q, chips_left_d;
  logic [FILL_W-1:0] fill_cnt_q,   fill_cnt_d;
  logic [WORD_W-1:0] asm_q,        asm_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q,  mem_wdata_d;

  logic              wr_stall;
  logic              wr_accept;
  logic              take_chip;
  logic              last_chip;
  logic              word_full;
  logic [FILL_W-1:0] bit_idx;
  logic [WORD_W-1:0] asm_next;

  // Write channel status for this cycle.
  assign wr_stall  = mem_we_q & ~mem_ready;
  assign wr_accept = mem_we_q &  mem_ready;

  // A chip is taken only while the output register is free or being drained
  // this very cycle, so a completed word always has somewhere to go.
  assign take_chip = (state_q == ST_RUN) && (chips_left_q != '0) && !wr_stall;
  assign last_chip = take_chip && (chips_left_q == CNT_W'(1));
  assign word_full = take_chip && (fill_cnt_q == FILL_W'(WORD_W - 1));

`ifdef FACQ_PRN_PACK_MSB_FIRST_EN
  assign bit_idx = FILL_W'(WORD_W - 1) - fill_cnt_q;
`else
  assign bit_idx = fill_cnt_q;
`endif

  always_comb begin
    state_d      = state_q;
    chips_left_d = chips_left_q;
    fill_cnt_d   = fill_cnt_q;
    asm_d        = asm_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    asm_next     = asm_q;

    // Retire the pending write; the address moves on only once accepted.
    if (wr_accept) begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end

    // Chip capture. A completed (or final partial) word goes straight to the
    // output register; the assembly register restarts empty so the unfilled
    // positions of a partial word are zero.
    if (take_chip) begin
      asm_next[bit_idx] = chip_in;
      chips_left_d      = chips_left_q - CNT_W'(1);
      if (word_full || last_chip) begin
        mem_wdata_d = asm_next;
        mem_we_d    = 1'b1;
        asm_d       = '0;
        fill_cnt_d  = '0;
      end else begin
        asm_d      = asm_next;
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (chip_num == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_INIT;
            chips_left_d = chip_num;
            mem_addr_d   = base_addr;
            fill_cnt_d   = '0;
            asm_d        = '0;
          end
        end
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_chip) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (wr_accept || !mem_we_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything: drop the partial word and any pending
    // write, and leave the address where it was.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      chips_left_d = '0;
      fill_cnt_d   = '0;
      asm_d        = '0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      chips_left_q <= '0;
      fill_cnt_q   <= '0;
      asm_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      chips_left_q <= chips_left_d;
      fill_cnt_q   <= fill_cnt_d;
      asm_q        <= asm_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gen_init  = (state_q == ST_INIT);
  assign gen_we    = take_chip;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

`ifndef SYNTHESIS
  // The generator must never be asked to init and shift in the same cycle.
  a_init_we_excl : assert property (@(posedge clk) disable iff (!resetn)
    !(gen_init && gen_we));

  // A stalled write keeps its address and data until accepted (or aborted).
  a_stall_hold : assert property (@(posedge clk) disable iff (!resetn)
    (mem_we && !mem_ready && !abort) |=>
      (mem_we && $stable(mem_addr) && $stable(mem_wdata)));
`endif

endmodule

// File: tb/tb_facq_prn_packer.sv
module tb_facq_prn_packer;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  chip_num;
  logic [ADDR_W-1:0] base_addr;
  logic              gen_init;
  logic              gen_we;
  logic              chip_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;

  facq_prn_packer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .chip_num  (chip_num),
    .base_addr (base_addr),
    .gen_init  (gen_init),
    .gen_we    (gen_we),
    .chip_in   (chip_in),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // chips[] is the generator's chip sequence after an init. The expected write
  // list is computed directly from the packing rule.
  logic              chips [0:255];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [WORD_W-1:0] exp_data_q [$];

  function automatic logic [WORD_W-1:0] model_word(input int w, input int n);
    logic [WORD_W-1:0] d;
    d = '0;
    for (int j = 0; j < WORD_W; j++) begin
      int k;
      k = w * WORD_W + j;
      if (k < n) begin
`ifdef FACQ_PRN_PACK_MSB_FIRST_EN
        d[WORD_W-1-j] = chips[k];
`else
        d[j] = chips[k];
`endif
      end
    end
    return d;
  endfunction

  task automatic build_model(input int n, input int base);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int w = 0; w < (n + WORD_W - 1) / WORD_W; w++) begin
      exp_addr_q.push_back(ADDR_W'(base + w));
      exp_data_q.push_back(model_word(w, n));
    end
  endtask

  // ---------------- generator / memory stand-ins ----------------
  int   cyc = 0;
  int   start_cyc = 0;
  int   chip_idx = 0;
  int   stall_left = 0;
  logic we_seen = 1'b0;
  logic init_seen = 1'b0;

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (init_seen) chip_idx = 0;
    else if (we_seen) chip_idx++;
    chip_in = chips[chip_idx[7:0]];
    if (mem_we && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  int   n_done, done_off, n_init, init_off, n_we, first_we_off, n_wr, n_stall;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [WORD_W-1:0] prev_data;

  always @(negedge clk) begin
    we_seen   = gen_we;
    init_seen = gen_init;
    if (resetn) begin
      if (gen_init) begin
        n_init++;
        init_off = cyc - start_cyc;
        check("init_we_excl", 64'(gen_we), 64'd0);
      end
      if (gen_we) begin
        if (n_we == 0) first_we_off = cyc - start_cyc;
        n_we++;
      end
      if (mem_we && !mem_ready) begin
        n_stall++;
        check("stall_gen_we", 64'(gen_we), 64'd0);
      end
      if (prev_stall) begin
        check("hold_we",   64'(mem_we),    64'd1);
        check("hold_addr", 64'(mem_addr),  64'(prev_addr));
        check("hold_data", 64'(mem_wdata), 64'(prev_data));
      end
      prev_stall = mem_we && !mem_ready && !abort;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (mem_we && mem_ready) begin
        n_wr++;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write: got write 0x%0h at 0x%0h, required none", mem_wdata, mem_addr);
        end else begin
          check("wr_addr", 64'(mem_addr),  64'(exp_addr_q.pop_front()));
          check("wr_data", 64'(mem_wdata), 64'(exp_data_q.pop_front()));
        end
      end
      if (done) begin
        n_done++;
        done_off = cyc - start_cyc;
        check("done_all_written", 64'(exp_addr_q.size()), 64'd0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_stats();
    n_done = 0; done_off = -1; n_init = 0; init_off = -1;
    n_we = 0; first_we_off = -1; n_wr = 0; n_stall = 0;
  endtask

  task automatic do_start(input int n, input int base);
    @(posedge clk); #1;
    chip_num  = CNT_W'(n);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (n_done == 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", 64'(n_done), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input string tag, input int n, input int base, input int stall,
                          input int exp_done, input int exp_words);
    reset_stats();
    stall_left = stall;
    do_start(n, base);
    wait_done(n + 60);
    check({tag, "_done_cycle"}, 64'(done_off), 64'(exp_done));
    check({tag, "_done_once"},  64'(n_done),   64'd1);
    check({tag, "_writes"},     64'(n_wr),     64'(exp_words));
    check({tag, "_gen_we_cnt"}, 64'(n_we),     64'(n));
    check({tag, "_init_cnt"},   64'(n_init),   64'(n != 0));
    if (n != 0) begin
      check({tag, "_init_cycle"},   64'(init_off),     64'd1);
      check({tag, "_first_we_cyc"}, 64'(first_we_off), 64'd2);
    end
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

`ifdef FACQ_PRN_PACK_MSB_FIRST_EN
  localparam logic [WORD_W-1:0] ALT_WORD  = 32'hAAAA_AAAA;
  localparam logic [WORD_W-1:0] TAIL_WORD = 32'h8000_0000;
`else
  localparam logic [WORD_W-1:0] ALT_WORD  = 32'h5555_5555;
  localparam logic [WORD_W-1:0] TAIL_WORD = 32'h0000_0001;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; chip_num = '0; base_addr = '0;
    mem_ready = 1'b1; chip_in = 1'b0;
    for (int i = 0; i < 256; i++) chips[i] = 1'b0;
    reset_stats();
    #1;
    check("rst_gen_init",  64'(gen_init),  64'd0);
    check("rst_gen_we",    64'(gen_we),    64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // 64 alternating chips starting with 1, addresses 0x3FE / 0x3FF.
    for (int i = 0; i < 256; i++) chips[i] = (i % 2 == 0);
    build_model(64, 10'h3FE);
    check("s1_model_w0",   64'(exp_data_q[0]), 64'(ALT_WORD));
    check("s1_model_w1",   64'(exp_data_q[1]), 64'(ALT_WORD));
    check("s1_model_a1",   64'(exp_addr_q[1]), 64'h3FF);
    run_fill("s1", 64, 10'h3FE, 0, 67, 2);

    // 33 ones, address wrap 0x3FF -> 0x000, zero-padded tail word.
    for (int i = 0; i < 256; i++) chips[i] = 1'b1;
    build_model(33, 10'h3FF);
    check("s2_model_w0", 64'(exp_data_q[0]), 64'hFFFF_FFFF);
    check("s2_model_w1", 64'(exp_data_q[1]), 64'(TAIL_WORD));
    check("s2_model_a1", 64'(exp_addr_q[1]), 64'h000);
    run_fill("s2", 33, 10'h3FF, 0, 36, 2);

    // First write stalled 5 cycles: same data, everything 5 cycles later.
    for (int i = 0; i < 256; i++) chips[i] = (i % 2 == 0);
    build_model(64, 10'h3FE);
    run_fill("s3", 64, 10'h3FE, 5, 72, 2);
    check("s3_stall_cycles", 64'(n_stall), 64'd5);

    // Empty fill: done right after start, nothing else.
    build_model(0, 10'h010);
    run_fill("s4", 0, 10'h010, 0, 1, 0);

    // Abort 10 cycles into RUN, then a fresh fill at its own base.
    reset_stats();
    stall_left = 0;
    build_model(64, 10'h050);
    do_start(64, 10'h050);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    check("ab_gen_we", 64'(gen_we), 64'd0);
    check("ab_mem_we", 64'(mem_we), 64'd0);
    check("ab_busy",   64'(busy),   64'd0);
    check("ab_done",   64'(done),   64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("ab_no_done",   64'(n_done), 64'd0);
    check("ab_no_writes", 64'(n_wr),   64'd0);
    for (int i = 0; i < 256; i++) chips[i] = (i % 3 == 0);
    build_model(40, 10'h100);
    check("s5_model_a0", 64'(exp_addr_q[0]), 64'h100);
    check("s5_model_w1", 64'(exp_data_q[1]), 64'(model_word(1, 40)));
    run_fill("s5", 40, 10'h100, 0, 43, 2);

    // Asynchronous reset mid-RUN.
    reset_stats();
    build_model(64, 10'h000);
    do_start(64, 10'h000);
    repeat (18) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("mr_gen_init",  64'(gen_init),  64'd0);
    check("mr_gen_we",    64'(gen_we),    64'd0);
    check("mr_mem_we",    64'(mem_we),    64'd0);
    check("mr_mem_addr",  64'(mem_addr),  64'd0);
    check("mr_mem_wdata", 64'(mem_wdata), 64'd0);
    check("mr_busy",      64'(busy),      64'd0);
    check("mr_done",      64'(done),      64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mr_idle_busy", 64'(busy),   64'd0);
    check("mr_no_done",   64'(n_done), 64'd0);

    // Fresh fill; a second start while busy must be ignored.
    reset_stats();
    for (int i = 0; i < 256; i++) chips[i] = (i % 4 == 1);
    build_model(8, 10'h020);
    do_start(8, 10'h020);
    repeat (2) @(posedge clk);
    #1;
    chip_num  = CNT_W'(16);
    base_addr = 10'h200;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(80);
    check("s6_done_cycle", 64'(done_off), 64'd11);
    check("s6_writes",     64'(n_wr),     64'd1);
    check("s6_gen_we_cnt", 64'(n_we),     64'd8);
    check("s6_init_cnt",   64'(n_init),   64'd1);
    check("s6_busy_after", 64'(busy),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
